// File: rtl/time_set_demux.sv
// -----------------------------------------------------------------------------
// time_set_demux
//   Time-editing writer for the two 24-bit BCD time registers (hh:mm:ss).
//   A mode press while idle captures dest_sel and preloads a working copy from
//   the selected source. Further mode presses step hours -> minutes -> seconds
//   -> commit. up/down presses edit the active field with BCD wrap. Commit
//   writes the working copy to wr_data and pulses the write strobe of the
//   captured destination for one cycle.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   btn_mode            enter edit / advance field (single-cycle pulse)
//   btn_up, btn_down    increment / decrement active field (pulses)
//   btn_cancel          abort edit without writing (pulse)
//   dest_sel            0 = clock time, 1 = nap/alarm time (sampled on entry)
//   cur_time1/2         current destination values used for preload
//   edit_time           working BCD time for display
//   field               0 idle, 1 hours, 2 minutes, 3 seconds
//   editing             high in any edit state
//   blink               blink phase for the active field
//   wr_data             committed time (holds after commit)
//   wr_en1/wr_en2       one-cycle write strobes to destination 0 / 1
// -----------------------------------------------------------------------------
module time_set_demux #(
  parameter int HOUR_MAX  = 23,
  parameter int MIN_MAX   = 59,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_cancel,
  input  logic        dest_sel,
  input  logic [23:0] cur_time1,
  input  logic [23:0] cur_time2,
  output logic [23:0] edit_time,
  output logic [1:0]  field,
  output logic        editing,
  output logic        blink,
  output logic [23:0] wr_data,
  output logic        wr_en1,
  output logic        wr_en2
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] EDIT_HH = 3'd1;
  localparam logic [2:0] EDIT_MM = 3'd2;
  localparam logic [2:0] EDIT_SS = 3'd3;
  localparam logic [2:0] COMMIT  = 3'd4;

  localparam logic [7:0] HOUR_MAX_BIN = 8'(HOUR_MAX);
  localparam logic [7:0] MIN_MAX_BIN  = 8'(MIN_MAX);
  localparam logic [7:0] HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
  localparam logic [7:0] MIN_MAX_BCD  = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

  localparam int         CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [2:0]       state;
  logic [2:0]       next_field_state;
  logic             dest_q;
  logic [CNT_W-1:0] blink_cnt;
  logic [23:0]      edited;
  logic             do_edit;

  // One BCD field step with wrap. Anything that is not a legal 00..max value
  // (bad digit or too large) snaps to 00 on up and to max on down.
  function automatic logic [7:0] bcd_step(input logic [7:0] v,
                                          input logic       inc,
                                          input logic [7:0] max_bin,
                                          input logic [7:0] max_bcd);
    logic [3:0] t;
    logic [3:0] o;
    logic [7:0] bin;
    logic       valid;
    t     = v[7:4];
    o     = v[3:0];
    bin   = 8'(t) * 8'd10 + 8'(o);
    valid = (t <= 4'd9) && (o <= 4'd9) && (bin <= max_bin);
    if (inc) begin
      if (!valid || bin == max_bin) bcd_step = 8'h00;
      else if (o == 4'd9)           bcd_step = {t + 4'd1, 4'd0};
      else                          bcd_step = {t, o + 4'd1};
    end else begin
      if (!valid || bin == 8'd0)    bcd_step = max_bcd;
      else if (o == 4'd0)           bcd_step = {t - 4'd1, 4'd9};
      else                          bcd_step = {t, o - 4'd1};
    end
  endfunction

  // up and down together cancel out.
  assign do_edit = btn_up ^ btn_down;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    edited           = edit_time;
    next_field_state = IDLE;
    case (state)
      EDIT_HH: begin
        edited[23:16]    = bcd_step(edit_time[23:16], btn_up, HOUR_MAX_BIN, HOUR_MAX_BCD);
        next_field_state = EDIT_MM;
      end
      EDIT_MM: begin
        edited[15:8]     = bcd_step(edit_time[15:8], btn_up, MIN_MAX_BIN, MIN_MAX_BCD);
        next_field_state = EDIT_SS;
      end
      EDIT_SS: begin
        edited[7:0]      = bcd_step(edit_time[7:0], btn_up, MIN_MAX_BIN, MIN_MAX_BCD);
        next_field_state = COMMIT;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dest_q    <= 1'b0;
      edit_time <= '0;
      wr_data   <= '0;
      wr_en1    <= 1'b0;
      wr_en2    <= 1'b0;
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else begin
      // Strobes default low; only the edit-to-commit transition raises one.
      wr_en1 <= 1'b0;
      wr_en2 <= 1'b0;
      case (state)
        IDLE: begin
          blink_cnt <= '0;
          blink     <= 1'b0;
          if (btn_mode) begin
            dest_q    <= dest_sel;
            edit_time <= dest_sel ? cur_time2 : cur_time1;
            state     <= EDIT_HH;
          end
        end
        EDIT_HH, EDIT_MM, EDIT_SS: begin
          if (btn_cancel) begin
            state     <= IDLE;
            blink_cnt <= '0;
            blink     <= 1'b0;
          end else if (btn_mode) begin
            state     <= next_field_state;
            blink_cnt <= '0;
            blink     <= 1'b0;
            if (state == EDIT_SS) begin
              // Strobe and data are registered together so they are both
              // visible during the single COMMIT cycle.
              wr_data <= edit_time;
              wr_en1  <= ~dest_q;
              wr_en2  <= dest_q;
            end
          end else if (do_edit) begin
            edit_time <= edited;
            blink_cnt <= '0;
            blink     <= 1'b0;
          end else if (blink_cnt == CNT_LAST) begin
            blink_cnt <= '0;
            blink     <= ~blink;
          end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
          end
        end
        COMMIT: begin
          state     <= IDLE;
          blink_cnt <= '0;
          blink     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign editing = (state == EDIT_HH) || (state == EDIT_MM) || (state == EDIT_SS);
  assign field   = editing ? state[1:0] : 2'd0;

endmodule

// File: tb/tb_time_set_demux.sv
// -----------------------------------------------------------------------------
// tb_time_set_demux
//   Directed bench for time_set_demux with BLINK_DIV = 4. Inputs change on the
//   falling edge; outputs are sampled on the falling edge after the rising
//   edge that acted on them.
// -----------------------------------------------------------------------------
module tb_time_set_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_mode = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        btn_cancel = 1'b0;
  logic        dest_sel = 1'b0;
  logic [23:0] cur_time1 = '0;
  logic [23:0] cur_time2 = '0;
  logic [23:0] edit_time;
  logic [1:0]  field;
  logic        editing;
  logic        blink;
  logic [23:0] wr_data;
  logic        wr_en1;
  logic        wr_en2;

  int checks = 0;
  int errors = 0;

  time_set_demux #(.BLINK_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_cancel (btn_cancel),
    .dest_sel   (dest_sel),
    .cur_time1  (cur_time1),
    .cur_time2  (cur_time2),
    .edit_time  (edit_time),
    .field      (field),
    .editing    (editing),
    .blink      (blink),
    .wr_data    (wr_data),
    .wr_en1     (wr_en1),
    .wr_en2     (wr_en2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle button pulse; returns on the falling edge after it was consumed.
  task automatic press(input logic m, input logic u, input logic d, input logic c);
    @(negedge clk);
    btn_mode = m; btn_up = u; btn_down = d; btn_cancel = c;
    @(negedge clk);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_cancel = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " editing"}, 32'(editing), 32'd0);
    check({tag, " field"},   32'(field),   32'd0);
    check({tag, " wr_en1"},  32'(wr_en1),  32'd0);
    check({tag, " wr_en2"},  32'(wr_en2),  32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");
    check("reset edit_time", 32'(edit_time), 32'h0);
    check("reset wr_data",   32'(wr_data),   32'h0);
    check("reset blink",     32'(blink),     32'd0);

    // Idle button pulses are ignored
    press(0, 1, 0, 0); check_idle("idle up");
    press(0, 0, 1, 0); check_idle("idle down");
    press(0, 0, 0, 1); check_idle("idle cancel");
    check("idle edit_time", 32'(edit_time), 32'h0);

    // Destination 0: wrap every field upward
    cur_time1 = 24'h235959; cur_time2 = 24'h111111; dest_sel = 1'b0;
    press(1, 0, 0, 0);
    check("d0 entry field", 32'(field), 32'd1);
    check("d0 entry editing", 32'(editing), 32'd1);
    check("d0 preload", 32'(edit_time), 32'h235959);
    press(0, 1, 0, 0); check("d0 hh wrap", 32'(edit_time), 32'h005959);
    press(1, 0, 0, 0); check("d0 field mm", 32'(field), 32'd2);
    press(0, 1, 0, 0); check("d0 mm wrap", 32'(edit_time), 32'h000059);
    press(1, 0, 0, 0); check("d0 field ss", 32'(field), 32'd3);
    press(0, 1, 0, 0); check("d0 ss wrap", 32'(edit_time), 32'h000000);
    cur_time1 = 24'h999999;
    press(1, 0, 0, 0);
    check("d0 commit wr_en1", 32'(wr_en1), 32'd1);
    check("d0 commit wr_en2", 32'(wr_en2), 32'd0);
    check("d0 commit wr_data", 32'(wr_data), 32'h000000);
    check("d0 commit editing", 32'(editing), 32'd0);
    @(negedge clk);
    check("d0 after wr_en1", 32'(wr_en1), 32'd0);
    check("d0 after wr_en2", 32'(wr_en2), 32'd0);

    // Destination 1: wrap downward; dest_sel change mid-edit ignored
    cur_time1 = 24'h123456; cur_time2 = 24'h000000; dest_sel = 1'b1;
    press(1, 0, 0, 0);
    check("d1 preload", 32'(edit_time), 32'h000000);
    dest_sel = 1'b0;
    press(0, 0, 1, 0); check("d1 hh down wrap", 32'(edit_time), 32'h230000);
    press(1, 0, 0, 0);
    press(0, 0, 1, 0); check("d1 mm down wrap", 32'(edit_time), 32'h235900);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    check("d1 commit wr_en2", 32'(wr_en2), 32'd1);
    check("d1 commit wr_en1", 32'(wr_en1), 32'd0);
    check("d1 commit wr_data", 32'(wr_data), 32'h235900);
    @(negedge clk);
    check("d1 after wr_en2", 32'(wr_en2), 32'd0);
    check("d1 wr_data hold", 32'(wr_data), 32'h235900);

    // BCD carry / borrow on minutes, then cancel holds edit_time
    cur_time1 = 24'h120900; dest_sel = 1'b0;
    press(1, 0, 0, 0); press(1, 0, 0, 0);
    press(0, 1, 0, 0); check("mm carry 09->10", 32'(edit_time), 32'h121000);
    press(0, 0, 1, 0); check("mm borrow 10->09", 32'(edit_time), 32'h120900);
    for (int i = 0; i < 9; i++) press(0, 0, 1, 0);
    check("mm down to 00", 32'(edit_time), 32'h120000);
    press(0, 0, 1, 0); check("mm 00->59", 32'(edit_time), 32'h125900);
    press(0, 0, 0, 1);
    check_idle("cancel mm");
    check("cancel holds edit_time", 32'(edit_time), 32'h125900);
    check("cancel keeps wr_data", 32'(wr_data), 32'h235900);

    // Out-of-range preload on minutes
    cur_time1 = 24'h00FA00;
    press(1, 0, 0, 0); press(1, 0, 0, 0);
    press(0, 1, 0, 0); check("bad mm up", 32'(edit_time), 32'h000000);
    press(0, 0, 0, 1);
    press(1, 0, 0, 0); press(1, 0, 0, 0);
    press(0, 0, 1, 0); check("bad mm down", 32'(edit_time), 32'h005900);
    press(0, 0, 0, 1);

    // Priority
    cur_time1 = 24'h101010;
    press(1, 0, 0, 0);
    press(1, 1, 0, 0);
    check("mode+up field", 32'(field), 32'd2);
    check("mode+up hours kept", 32'(edit_time), 32'h101010);
    press(0, 1, 1, 0);
    check("up+down no change", 32'(edit_time), 32'h101010);
    press(1, 0, 0, 0);
    check("prio at ss", 32'(field), 32'd3);
    press(1, 0, 0, 1);
    check_idle("cancel+mode");
    @(negedge clk);
    check("cancel+mode no late wr_en1", 32'(wr_en1), 32'd0);

    // Blink with BLINK_DIV = 4
    cur_time1 = 24'h050505;
    press(1, 0, 0, 0);
    check("blink entry", 32'(blink), 32'd0);
    repeat (3) @(negedge clk); check("blink c3", 32'(blink), 32'd0);
    @(negedge clk);            check("blink c4", 32'(blink), 32'd1);
    repeat (3) @(negedge clk); check("blink c7", 32'(blink), 32'd1);
    @(negedge clk);            check("blink c8", 32'(blink), 32'd0);
    repeat (4) @(negedge clk); check("blink c12", 32'(blink), 32'd1);
    press(0, 1, 0, 0);
    check("blink cleared by up", 32'(blink), 32'd0);
    check("blink up value", 32'(edit_time), 32'h060505);

    // Reset mid EDIT_MM
    press(1, 0, 0, 0);
    check("pre-reset field", 32'(field), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle("mid reset");
    check("mid reset edit_time", 32'(edit_time), 32'h0);
    check("mid reset wr_data", 32'(wr_data), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cur_time1 = 24'h070809;
    press(1, 0, 0, 0);
    check("re-entry field", 32'(field), 32'd1);
    check("re-entry preload", 32'(edit_time), 32'h070809);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
